// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder + Viterbi decoder chain.
// Latency: start accepted at edge 0, done in cycle FRAME_LEN+2+DEC_LAT (38 for defaults).
// Backpressure: none; start is honoured only in IDLE, abort returns to IDLE from any state.
//
// Ports:
//   clk        rising-edge clock
//   res        asynchronous active-low reset
//   start      frame request, sampled only in IDLE (abort wins over start)
//   abort      synchronous abort back to IDLE, no done
//   frame_in   frame, latched when start is accepted
//   busy       high in CLEAR/ENCODE/TAIL/DRAIN/DONE
//   done       1-cycle pulse; frame_out/err_count valid from this cycle
//   enc_clr    clears encoder shift register and decoder path metrics
//   enc_en     chain advance enable (encoder and decoder)
//   enc_bit    bit into the encoder; 0 outside ENCODE
//   dec_bit    decoder output bit
//   frame_out  decoded frame; holds until the next accepted start
//   err_count  popcount(latched frame ^ frame_out); holds like frame_out
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 20,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FRAME_LEN-1:0] frame_in,
    output logic                 busy,
    output logic                 done,
    output logic                 enc_clr,
    output logic                 enc_en,
    output logic                 enc_bit,
    input  logic                 dec_bit,
    output logic [FRAME_LEN-1:0] frame_out,
    output logic [CW-1:0]        err_count
);

    // Tail counter is sized so that TAIL_LEN = 0 still yields a legal width.
    localparam int TW = $clog2(TAIL_LEN + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ENCODE,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] frm_lat;   // frame as accepted, reference for err_count
    logic [FRAME_LEN-1:0] tx_sr;     // MSB-first transmit shifter
    logic [CW-1:0]        bit_cnt;   // data bits already presented on enc_bit
    logic [CW-1:0]        cap_cnt;   // decoded data bits captured so far
    logic [TW-1:0]        tail_cnt;  // tail bits presented, counting from 1
    logic [DEC_LAT-1:0]   tag_dl;    // "this cycle carried a data bit" tags

    logic                 tap;
    logic                 cap_last;
    logic [FRAME_LEN-1:0] cap_word;

    function automatic logic [CW-1:0] popcount(input logic [FRAME_LEN-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // A tag entered during an ENCODE cycle reaches the tap exactly DEC_LAT
    // cycles later, i.e. in the cycle the same bit appears on dec_bit.
    assign tap      = tag_dl[DEC_LAT-1];
    assign cap_word = {frame_out[FRAME_LEN-2:0], dec_bit};
    assign cap_last = tap && (cap_cnt == CW'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            enc_clr   <= 1'b0;
            enc_en    <= 1'b0;
            enc_bit   <= 1'b0;
            frame_out <= '0;
            err_count <= '0;
            frm_lat   <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            cap_cnt   <= '0;
            tail_cnt  <= '0;
            tag_dl    <= '0;
        end else begin
            tag_dl <= (tag_dl << 1) | DEC_LAT'(state == S_ENCODE);

            // Capture path runs independently of the FSM state; only tagged
            // cycles are sampled, so tail bits never reach frame_out.
            if (tap && (cap_cnt != CW'(FRAME_LEN))) begin
                frame_out <= cap_word;
                cap_cnt   <= cap_cnt + 1'b1;
            end
            // err_count uses the word as it will look after this final capture.
            if (cap_last) begin
                err_count <= popcount(frm_lat ^ cap_word);
            end

            if (abort && (state != S_IDLE)) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
                enc_clr <= 1'b0;
                enc_en  <= 1'b0;
                enc_bit <= 1'b0;
                tag_dl  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state     <= S_CLEAR;
                            frm_lat   <= frame_in;
                            tx_sr     <= frame_in;
                            frame_out <= '0;
                            err_count <= '0;
                            bit_cnt   <= '0;
                            cap_cnt   <= '0;
                            tail_cnt  <= '0;
                            busy      <= 1'b1;
                            enc_clr   <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        state   <= S_ENCODE;
                        enc_clr <= 1'b0;
                        enc_en  <= 1'b1;
                        enc_bit <= tx_sr[FRAME_LEN-1];
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= CW'(1);
                    end
                    S_ENCODE: begin
                        if (bit_cnt == CW'(FRAME_LEN)) begin
                            enc_bit <= 1'b0;
                            if (TAIL_LEN == 0) begin
                                state <= S_DRAIN;
                            end else begin
                                state    <= S_TAIL;
                                tail_cnt <= TW'(1);
                            end
                        end else begin
                            enc_bit <= tx_sr[FRAME_LEN-1];
                            tx_sr   <= tx_sr << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_TAIL: begin
                        // With DEC_LAT == TAIL_LEN the last capture can land
                        // inside the tail, so completion is checked here too.
                        if (cap_last) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            enc_en  <= 1'b0;
                            enc_bit <= 1'b0;
                        end else if (tail_cnt == TW'(TAIL_LEN)) begin
                            state <= S_DRAIN;
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (cap_last || (cap_cnt == CW'(FRAME_LEN))) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            enc_en  <= 1'b0;
                            enc_bit <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        enc_clr <= 1'b0;
                        enc_en  <= 1'b0;
                        enc_bit <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a delay-line decoder model.
// Cycle n of a frame is counted from the edge that accepts start (edge 0).
// The decoder model can flip selected captured bits to produce bit errors.
module tb_viterbi_frame_ctrl;

    localparam int FL = 16;
    localparam int DL = 20;
    localparam int CW = $clog2(FL + 1);

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FL-1:0] frame_in = '0;
    logic          busy, done, enc_clr, enc_en, enc_bit, dec_bit;
    logic [FL-1:0] frame_out;
    logic [CW-1:0] err_count;

    viterbi_frame_ctrl dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .abort     (abort),
        .frame_in  (frame_in),
        .busy      (busy),
        .done      (done),
        .enc_clr   (enc_clr),
        .enc_en    (enc_en),
        .enc_bit   (enc_bit),
        .dec_bit   (dec_bit),
        .frame_out (frame_out),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Ideal decoder: enc_bit from cycle c reappears on dec_bit in cycle c+DL.
    int            cyc = 0;
    logic [DL-1:0] hist = '0;
    int            t0 = 0;
    bit            flip_en = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hist <= {hist[DL-2:0], enc_bit};
    end

    // Capture index k lands in frame cycle 22+k; flip captures 0, 7 and 15
    // (frame bits 15, 8 and 0).
    function automatic bit flip_now(int rel);
        return flip_en && (rel == 22 || rel == 29 || rel == 37);
    endfunction

    assign dec_bit = hist[DL-1] ^ flip_now(cyc - t0);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-frame observations gathered by run_frame.
    int            done_cyc, done_n, en_first, en_last, en_n, clr_n, clr_cyc;
    int            bit_bad, tail_bad;
    logic [FL-1:0] fo1;

    // Starts a frame and observes it until done (or 60 cycles). start is
    // also driven high during cycles pulse_a/pulse_b, or kept high if hold.
    // Returns while the bench sits in the done cycle.
    task automatic run_frame(input logic [FL-1:0] f, input int pulse_a,
                             input int pulse_b, input bit hold);
        logic [FL-1:0] sh;
        sh       = f;
        frame_in = f;
        start    = 1'b1;
        step();
        t0       = cyc - 1;
        start    = hold;
        done_cyc = -1; done_n = 0; en_first = -1; en_last = -1; en_n = 0;
        clr_n    = 0;  clr_cyc = -1; bit_bad = 0; tail_bad = 0; fo1 = 'x;
        for (int n = 1; n <= 60; n++) begin
            if (n == 1) fo1 = frame_out;
            if (enc_en) begin
                en_n++;
                if (en_first < 0) en_first = n;
                en_last = n;
            end
            if (enc_clr) begin
                clr_n++;
                clr_cyc = n;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (n >= 2 && n <= 17) begin
                if (enc_bit !== sh[FL-1]) bit_bad++;
                sh = sh << 1;
            end else if (enc_bit !== 1'b0) begin
                tail_bad++;
            end
            start = hold || (n == pulse_a) || (n == pulse_b);
            if (done_cyc == n) break;
            step();
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enc_en", enc_en, 0);
        chk("rst_enc_clr", enc_clr, 0);
        chk("rst_enc_bit", enc_bit, 0);
        chk("rst_frame_out", frame_out, 0);
        chk("rst_err", err_count, 0);
        step();
        step();
        @(negedge clk);
        res = 1'b1;
        step();

        // 1: ideal chain, D300
        run_frame(16'hD300, -1, -1, 1'b0);
        chk("t1_done_cyc", done_cyc, 38);
        chk("t1_done_n", done_n, 1);
        chk("t1_en_first", en_first, 2);
        chk("t1_en_last", en_last, 37);
        chk("t1_en_n", en_n, 36);
        chk("t1_clr_n", clr_n, 1);
        chk("t1_clr_cyc", clr_cyc, 1);
        chk("t1_bits", bit_bad, 0);
        chk("t1_tail", tail_bad, 0);
        chk("t1_busy_done", busy, 1);
        chk("t1_frame_out", frame_out, 16'hD300);
        chk("t1_err", err_count, 0);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_hold_out", frame_out, 16'hD300);

        // 2: FFFF then 0000 back to back
        run_frame(16'hFFFF, -1, -1, 1'b0);
        chk("t2a_frame_out", frame_out, 16'hFFFF);
        chk("t2a_err", err_count, 0);
        chk("t2a_tail", tail_bad, 0);
        chk("t2a_clr_n", clr_n, 1);
        step();
        run_frame(16'h0000, -1, -1, 1'b0);
        chk("t2b_cleared", fo1, 16'h0000);
        chk("t2b_frame_out", frame_out, 16'h0000);
        chk("t2b_err", err_count, 0);
        chk("t2b_tail", tail_bad, 0);
        chk("t2b_clr_n", clr_n, 1);
        chk("t2b_done_cyc", done_cyc, 38);
        step();

        // 3: decoder flips frame bits 15, 8, 0 of A5A5
        flip_en = 1'b1;
        run_frame(16'hA5A5, -1, -1, 1'b0);
        flip_en = 1'b0;
        chk("t3_frame_out", frame_out, 16'h24A4);
        chk("t3_err", err_count, 3);
        chk("t3_done_cyc", done_cyc, 38);
        step();

        // 4: start pulsed in ENCODE (cycle 5) and in DONE (cycle 38)
        run_frame(16'h5A3C, 5, 38, 1'b0);
        chk("t4_done_cyc", done_cyc, 38);
        chk("t4_frame_out", frame_out, 16'h5A3C);
        step();
        start = 1'b0;
        chk("t4_done_n", done_n, 1);
        chk("t4_busy_after", busy, 0);
        chk("t4_clr_after", enc_clr, 0);
        step();
        // start held high: next frame begins right after the IDLE cycle
        run_frame(16'h0F0F, -1, -1, 1'b1);
        chk("t4h_done_cyc", done_cyc, 38);
        chk("t4h_done_n", done_n, 1);
        chk("t4h_frame_out", frame_out, 16'h0F0F);
        step();
        chk("t4h_idle_busy", busy, 0);
        step();
        start = 1'b0;
        chk("t4h_restart_busy", busy, 1);
        chk("t4h_restart_clr", enc_clr, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4h_abort_busy", busy, 0);
        chk("t4h_abort_clr", enc_clr, 0);
        step();

        // 5: abort in cycle 5 (ENCODE), then restart immediately
        frame_in = 16'hC3A5;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_enc_en_c5", enc_en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_enc_en", enc_en, 0);
        chk("t5_done", done, 0);
        run_frame(16'h9B71, -1, -1, 1'b0);
        chk("t5_done_cyc", done_cyc, 38);
        chk("t5_done_n", done_n, 1);
        chk("t5_frame_out", frame_out, 16'h9B71);
        chk("t5_err", err_count, 0);
        step();

        // 6: async reset in DRAIN (cycle 25)
        frame_in = 16'hBEEF;
        start    = 1'b1;
        step();
        t0    = cyc - 1;
        start = 1'b0;
        for (int i = 0; i < 24; i++) step();
        chk("t6_busy_c25", busy, 1);
        chk("t6_partial", frame_out, 16'h0005);
        #2;
        res = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_enc_en", enc_en, 0);
        chk("t6_done", done, 0);
        chk("t6_frame_out", frame_out, 0);
        chk("t6_err", err_count, 0);
        @(negedge clk);
        res = 1'b1;
        step();
        run_frame(16'h1234, -1, -1, 1'b0);
        chk("t6_rec_done_cyc", done_cyc, 38);
        chk("t6_rec_frame_out", frame_out, 16'h1234);
        chk("t6_rec_err", err_count, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
